// File: rtl/reg_cmd_frontend.sv
// Byte-stream command parser feeding a register file: write/read strobes, held read response.
// Optional command parity check is compiled in with `define REG_CMD_PARITY_EN.
module reg_cmd_frontend #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        resp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              busy,
  output logic              timeout_err
`ifdef REG_CMD_PARITY_EN
  ,
  output logic              par_err
`endif
);

  typedef enum logic [1:0] {StIdle, StGetData, StRdWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]        to_cnt_q, to_cnt_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        resp_data_q, resp_data_d;
  logic              to_err_q, to_err_d;
  logic              par_err_q, par_err_d;

  logic accept;
  logic cmd_ok;
  logic unused_in;

  // Reserved command bits carry no meaning.
  assign unused_in = ^in_data;

`ifdef REG_CMD_PARITY_EN
  assign cmd_ok  = ~^in_data;
  assign par_err = par_err_q;
`else
  assign cmd_ok  = 1'b1;
`endif

  assign in_ready    = ~rst & ((state_q == StIdle) | (state_q == StGetData));
  assign accept      = in_valid & in_ready;
  assign busy        = (state_q != StIdle);
  assign resp_valid  = (state_q == StResp);
  assign resp_data   = resp_data_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign timeout_err = to_err_q;

  always_comb begin
    state_d     = state_q;
    cmd_addr_d  = cmd_addr_q;
    to_cnt_d    = to_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    resp_data_d = resp_data_q;
    to_err_d    = 1'b0;
    par_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && !cmd_ok) begin
          par_err_d = 1'b1;
        end else if (accept && in_data[7]) begin
          cmd_addr_d = in_data[ADDR_W-1:0];
          to_cnt_d   = '0;
          state_d    = StGetData;
        end else if (accept) begin
          rd_en_d   = 1'b1;
          rd_addr_d = in_data[ADDR_W-1:0];
          lat_cnt_d = '0;
          state_d   = StRdWait;
        end
      end
      StGetData: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cmd_addr_q;
          wr_data_d = in_data;
          state_d   = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
          if (to_cnt_d == 8'(TO_CYCLES)) begin
            to_cnt_d = '0;
            to_err_d = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StRdWait: begin
        // Edge count starts at the edge that raised rd_en.
        if (lat_cnt_q == 2'(RD_LAT - 1)) begin
          resp_data_d = rd_data;
          state_d     = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_addr_q  <= '0;
      to_cnt_q    <= '0;
      lat_cnt_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      resp_data_q <= '0;
      to_err_q    <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_addr_q  <= cmd_addr_d;
      to_cnt_q    <= to_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      resp_data_q <= resp_data_d;
      to_err_q    <= to_err_d;
      par_err_q   <= par_err_d;
    end
  end

endmodule

// File: tb/tb_reg_cmd_frontend.sv
// Randomized bench for reg_cmd_frontend against a transaction-level model with a register-file
// array; covers REG_CMD_PARITY_EN when that macro is defined.
module tb_reg_cmd_frontend;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned RD_LAT    = 1;
  localparam int unsigned TO_CYCLES = 255;

  logic              clk;
  logic              rst;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        resp_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              busy;
  logic              timeout_err;
`ifdef REG_CMD_PARITY_EN
  logic              par_err;
`endif

  reg_cmd_frontend #(
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT),
    .TO_CYCLES(TO_CYCLES)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
`ifdef REG_CMD_PARITY_EN
    ,
    .par_err    (par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  mem [2**ADDR_W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp_v, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("strobe_excl", 32'(wr_en & rd_en), 0);
  endtask

  function automatic logic [7:0] fix_par(input logic [7:0] b);
    logic [7:0] r;
    r = b;
`ifdef REG_CMD_PARITY_EN
    r[6] = ^{r[7], r[5:0]};
`endif
    return r;
  endfunction

  function automatic logic [7:0] mk_cmd(input logic is_wr, input logic [ADDR_W-1:0] a);
    logic [7:0] b;
    b = 8'($urandom);
    b[7] = is_wr;
    b[ADDR_W-1:0] = a;
    return fix_par(b);
  endfunction

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] data, input int gap);
    logic [ADDR_W-1:0] a;
    a = cmd[ADDR_W-1:0];
    in_data  = cmd;
    in_valid = 1'b1;
    #1 check("wr_cmd_ready", 32'(in_ready), 1);
    tick();
    check("wr_getdata", {busy, in_ready, wr_en}, 3'b110);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    for (int i = 0; i < gap; i++) begin
      tick();
      check("wr_gap", {busy, wr_en, timeout_err}, 3'b100);
    end
    in_data  = data;
    in_valid = 1'b1;
    tick();
    check("wr_strobe", 32'(wr_en), 1);
    check("wr_fields", {wr_addr, wr_data}, {a, data});
    check("wr_idle", {busy, in_ready, rd_en}, 3'b010);
    mem[a]   = data;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    tick();
    check("wr_one_pulse", 32'(wr_en), 0);
    check("wr_hold", {wr_addr, wr_data}, {a, data});
  endtask

  task automatic do_read(input logic [7:0] cmd, input int hold);
    logic [ADDR_W-1:0] a;
    logic [7:0]        exp_d;
    a          = cmd[ADDR_W-1:0];
    exp_d      = mem[a];
    resp_ready = (hold == 0);
    in_data    = cmd;
    in_valid   = 1'b1;
    #1 check("rd_cmd_ready", 32'(in_ready), 1);
    tick();
    check("rd_strobe", {rd_en, rd_addr}, {1'b1, a});
    check("rd_wait", {busy, in_ready, resp_valid, wr_en}, 4'b1000);
    // Junk presented while busy must never be consumed.
    in_data  = 8'($urandom);
    in_valid = 1'($urandom);
    for (int k = 1; k <= int'(RD_LAT); k++) begin
      rd_data = (k == int'(RD_LAT)) ? exp_d : 8'($urandom);
      tick();
      if (k < int'(RD_LAT)) check("rd_lat", {rd_en, resp_valid}, 2'b00);
    end
    rd_data = 8'($urandom);
    check("rd_resp_rise", {resp_valid, resp_data}, {1'b1, exp_d});
    check("rd_resp_state", {rd_en, in_ready, busy}, 3'b001);
    for (int h = 0; h < hold; h++) begin
      rd_data = 8'($urandom);
      tick();
      check("rd_resp_hold", {resp_valid, resp_data, in_ready}, {1'b1, exp_d, 1'b0});
    end
    resp_ready = 1'b1;
    tick();
    check("rd_resp_done", {resp_valid, in_ready, busy}, 3'b010);
    resp_ready = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic do_timeout(input logic [7:0] cmd);
    in_data  = cmd;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= int'(TO_CYCLES); i++) begin
      in_data = 8'($urandom);
      tick();
      if (i < int'(TO_CYCLES)) check("to_pending", {busy, timeout_err, wr_en}, 3'b100);
    end
    check("to_fire", {busy, timeout_err, wr_en}, 3'b010);
    tick();
    check("to_one_pulse", {timeout_err, wr_en, busy}, 3'b000);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    resp_ready = 1'b0;
    rd_data    = '0;
    for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 8'($urandom);

    tick();
    tick();
    check("rst_ready_low", 32'(in_ready), 0);
    rst = 1'b0;
    #1 check("rst_ready_rise", 32'(in_ready), 1);
    check("rst_outputs", {wr_en, wr_addr, wr_data, rd_en, rd_addr, resp_data, resp_valid, busy,
                          timeout_err}, 0);

    do_write(fix_par(8'h85), 8'h3C, 0);
    do_read(fix_par(8'h05), 10);

    do_timeout(fix_par(8'h82));
    do_read(fix_par(8'h02), 1);

    // Reset in the middle of a write abandons it; the pending byte becomes a fresh command.
    in_data  = fix_par(8'h87);
    in_valid = 1'b1;
    tick();
    rst     = 1'b1;
    in_data = fix_par(8'h11);
    #1 check("abort_ready_low", 32'(in_ready), 0);
    tick();
    rst = 1'b0;
    check("abort_outputs", {wr_en, wr_addr, wr_data, rd_en, rd_addr, resp_data, resp_valid,
                            busy, timeout_err}, 0);
    do_read(fix_par(8'h11), 2);

    do_write(fix_par(8'h81), 8'hAA, 0);
    do_read(fix_par(8'h01), 0);

`ifdef REG_CMD_PARITY_EN
    in_data  = 8'h83;
    in_valid = 1'b1;
    tick();
    check("par_err_pulse", {par_err, busy, wr_en, rd_en}, 4'b1000);
    in_valid = 1'b0;
    tick();
    check("par_err_clear", {par_err, busy, wr_en, rd_en}, 4'b0000);
    do_write(8'hC3, 8'h55, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op <= 3) do_write(mk_cmd(1'b1, ADDR_W'($urandom)), 8'($urandom), $urandom_range(0, 6));
      else if (op <= 7) do_read(mk_cmd(1'b0, ADDR_W'($urandom)), $urandom_range(0, 4));
      else if (op == 8) do_timeout(mk_cmd(1'b1, ADDR_W'($urandom)));
      else do_write(mk_cmd(1'b1, ADDR_W'($urandom)), 8'($urandom), int'(TO_CYCLES) - 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
